// File: rtl/fwd_arb_pkg.sv
// Shared constants for the forwarder arbiter: FSM state encoding and the
// helper that sizes the granted-VM index.
package fwd_arb_pkg;

   localparam logic [1:0] ARB_IDLE    = 2'd0;
   localparam logic [1:0] ARB_GRANT   = 2'd1;
   localparam logic [1:0] ARB_RELEASE = 2'd2;

   localparam int ARB_DEFAULT_N_VMS = 4;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int ARB_DEFAULT_SEL_W = sel_width(ARB_DEFAULT_N_VMS);

endpackage

// File: rtl/forwarder_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request scanning from
// last+1 upward with wrap-around; last itself has lowest priority.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic         valid,
   output logic [W-1:0] idx
);

   int pos;

   // Walk from the farthest offset down so the nearest requester wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = N; k >= 1; k--) begin
         pos = int'(last) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (req[W'(pos)]) begin
            valid = 1'b1;
            idx   = W'(pos);
         end
      end
   end

endmodule

// File: rtl/forwarder_arbiter.sv
// Shares one downstream forwarder among N_VMS VMs with packet-locked round-robin
// grants. Optional packet counter is built when FWD_ARB_PKT_COUNT_EN is defined.
module forwarder_arbiter
   import fwd_arb_pkg::*;
#(
   parameter int N_VMS             = 4,
   parameter int PACKET_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH        = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_VMS-1:0]                  vm_ready_for_fwd,
   output logic [PACKET_ADDR_WIDTH-1:0]      vm_fwd_rd_addr,
   output logic [N_VMS-1:0]                  vm_fwd_rd_en,
   input  logic [N_VMS*DATA_WIDTH-1:0]       vm_fwd_rd_data,
   output logic [N_VMS-1:0]                  vm_fwd_done,
   output logic                              fwd_ready,
   output logic [sel_width(N_VMS)-1:0]       fwd_sel,
   input  logic [PACKET_ADDR_WIDTH-1:0]      fwd_rd_addr,
   input  logic                              fwd_rd_en,
   output logic [DATA_WIDTH-1:0]             fwd_rd_data,
   input  logic                              fwd_done
`ifdef FWD_ARB_PKT_COUNT_EN
   ,
   output logic [31:0]                       pkt_count
`endif
);

   localparam int SEL_W = sel_width(N_VMS);

   logic [1:0]        state_reg, state_next;
   logic [SEL_W-1:0]  grant_reg, grant_next;
   logic [SEL_W-1:0]  last_grant_reg, last_grant_next;
   logic              pick_valid;
   logic [SEL_W-1:0]  pick_idx;
   logic              in_grant;
   logic [DATA_WIDTH-1:0] vm_data [N_VMS];

   rr_pick #(
      .N (N_VMS),
      .W (SEL_W)
   ) u_rr_pick (
      .req   (vm_ready_for_fwd),
      .last  (last_grant_reg),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_next      = ARB_GRANT;
               grant_next      = pick_idx;
               last_grant_next = pick_idx;
            end
         end
         ARB_GRANT: begin
            if (fwd_done) begin
               state_next = ARB_RELEASE;
            end
         end
         // Guard cycle lets the released VM drop its ready before re-arbitration.
         ARB_RELEASE: state_next = ARB_IDLE;
         default:     state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= ARB_IDLE;
         grant_reg      <= '0;
         last_grant_reg <= SEL_W'(N_VMS - 1);
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
      end
   end

`ifdef FWD_ARB_PKT_COUNT_EN
   logic [31:0] pkt_count_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pkt_count_reg <= '0;
      end else if (in_grant && fwd_done) begin
         pkt_count_reg <= pkt_count_reg + 32'd1;
      end
   end

   assign pkt_count = pkt_count_reg;
`endif

   assign in_grant       = (state_reg == ARB_GRANT);
   assign fwd_ready      = in_grant;
   assign fwd_sel        = grant_reg;
   assign vm_fwd_rd_addr = fwd_rd_addr;

   // Grant is stable from GRANT through RELEASE, so the one-cycle read latency survives.
   generate
      for (genvar gi = 0; gi < N_VMS; gi++) begin : g_vm
         logic hit;
         assign hit              = in_grant && (grant_reg == SEL_W'(gi));
         assign vm_fwd_rd_en[gi] = hit & fwd_rd_en;
         assign vm_fwd_done[gi]  = hit & fwd_done;
         assign vm_data[gi]      = vm_fwd_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign fwd_rd_data = vm_data[grant_reg];

endmodule

// File: tb/tb_forwarder_arbiter.sv
// Directed bench for forwarder_arbiter; pkt_count checks are built only when
// FWD_ARB_PKT_COUNT_EN is defined.
module tb_forwarder_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  vm_ready_for_fwd;
   logic [9:0]  vm_fwd_rd_addr;
   logic [3:0]  vm_fwd_rd_en;
   logic [255:0] vm_fwd_rd_data;
   logic [3:0]  vm_fwd_done;
   logic        fwd_ready;
   logic [1:0]  fwd_sel;
   logic [9:0]  fwd_rd_addr;
   logic        fwd_rd_en;
   logic [63:0] fwd_rd_data;
   logic        fwd_done;
`ifdef FWD_ARB_PKT_COUNT_EN
   logic [31:0] pkt_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] vm_q [4];

   always #5 clk = ~clk;

   forwarder_arbiter #(
      .N_VMS             (4),
      .PACKET_ADDR_WIDTH (10),
      .DATA_WIDTH        (64)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .vm_ready_for_fwd (vm_ready_for_fwd),
      .vm_fwd_rd_addr   (vm_fwd_rd_addr),
      .vm_fwd_rd_en     (vm_fwd_rd_en),
      .vm_fwd_rd_data   (vm_fwd_rd_data),
      .vm_fwd_done      (vm_fwd_done),
      .fwd_ready        (fwd_ready),
      .fwd_sel          (fwd_sel),
      .fwd_rd_addr      (fwd_rd_addr),
      .fwd_rd_en        (fwd_rd_en),
      .fwd_rd_data      (fwd_rd_data),
      .fwd_done         (fwd_done)
`ifdef FWD_ARB_PKT_COUNT_EN
      ,
      .pkt_count        (pkt_count)
`endif
   );

   // VM memory stub: registered read returning {vm_index+1, zeros, address}.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (vm_fwd_rd_en[i]) begin
            vm_q[i] <= {8'(i + 1), 46'd0, vm_fwd_rd_addr};
         end
      end
   end

   assign vm_fwd_rd_data = {vm_q[3], vm_q[2], vm_q[1], vm_q[0]};

   function automatic logic [63:0] exp_data(input int s, input logic [9:0] a);
      return {8'(s + 1), 46'd0, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int exp_sel);
      int n;
      n = 0;
      while (!fwd_ready && n < 10) begin
         tick();
         n++;
      end
      chk("grant_seen", 64'(fwd_ready), 64'd1);
      chk("fwd_sel", 64'(fwd_sel), 64'(exp_sel));
   endtask

   // Two reads then done; returns one step into RELEASE.
   task automatic pkt(input int sel, input logic [9:0] base);
      fwd_rd_addr = base;
      fwd_rd_en   = 1'b1;
      #1;
      chk("rd_en", 64'(vm_fwd_rd_en), 64'(4'b0001 << sel));
      chk("rd_addr", 64'(vm_fwd_rd_addr), 64'(base));
      tick();
      fwd_rd_addr = base + 10'd1;
      #1;
      chk("rd_data0", fwd_rd_data, exp_data(sel, base));
      tick();
      fwd_rd_en = 1'b0;
      fwd_done  = 1'b1;
      #1;
      chk("rd_data1", fwd_rd_data, exp_data(sel, base + 10'd1));
      chk("done", 64'(vm_fwd_done), 64'(4'b0001 << sel));
      tick();
      fwd_done = 1'b0;
      #1;
      chk("released", 64'(fwd_ready), 64'd0);
      chk("done_1cyc", 64'(vm_fwd_done), 64'd0);
      chk("rd_data_rel", fwd_rd_data, exp_data(sel, base + 10'd1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst              = 1'b0;
      vm_ready_for_fwd = 4'b1111;
      fwd_rd_addr      = '0;
      fwd_rd_en        = 1'b0;
      fwd_done         = 1'b0;

      // Reset held 3 cycles with everyone ready
      repeat (3) tick();
      chk("rst_ready", 64'(fwd_ready), 64'd0);
      chk("rst_sel", 64'(fwd_sel), 64'd0);
      chk("rst_rd_en", 64'(vm_fwd_rd_en), 64'd0);
      chk("rst_done", 64'(vm_fwd_done), 64'd0);
`ifdef FWD_ARB_PKT_COUNT_EN
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
      rst = 1'b1;
      tick();
      chk("first_grant_ready", 64'(fwd_ready), 64'd1);
      chk("first_grant_sel", 64'(fwd_sel), 64'd0);

      // Round-robin 0,1,2,3,0
      for (int p = 0; p < 5; p++) begin
         wait_grant(p % 4);
         pkt(p % 4, 10'(p * 16));
      end

      // Skip/wrap: grant 2, then 0 from 0011, then 1 from 0010
      vm_ready_for_fwd = 4'b0100;
      wait_grant(2);
      pkt(2, 10'h100);
      vm_ready_for_fwd = 4'b0011;
      wait_grant(0);
      pkt(0, 10'h120);
      vm_ready_for_fwd = 4'b0010;
      wait_grant(1);

      // Steering to VM1
      fwd_rd_addr = 10'h3A5;
      fwd_rd_en   = 1'b1;
      #1;
      chk("steer_rd_en", 64'(vm_fwd_rd_en), 64'h2);
      chk("steer_addr", 64'(vm_fwd_rd_addr), 64'h3A5);
      tick();
      fwd_rd_en = 1'b0;
      #1;
      chk("steer_data", fwd_rd_data, 64'h02000000000003A5);
      fwd_done = 1'b1;
      #1;
      chk("steer_done", 64'(vm_fwd_done), 64'h2);
      tick();
      fwd_done         = 1'b0;
      vm_ready_for_fwd = 4'b0000;
      #1;
      chk("steer_done_gone", 64'(vm_fwd_done), 64'd0);
      chk("steer_data_rel", fwd_rd_data, 64'h02000000000003A5);

      // Ignored inputs while IDLE
      tick();
      fwd_rd_en = 1'b1;
      fwd_done  = 1'b1;
      #1;
      chk("idle_rd_en", 64'(vm_fwd_rd_en), 64'd0);
      chk("idle_done", 64'(vm_fwd_done), 64'd0);
      chk("idle_ready", 64'(fwd_ready), 64'd0);
      tick();
      chk("idle_stays", 64'(fwd_ready), 64'd0);
      chk("idle_rd_en2", 64'(vm_fwd_rd_en), 64'd0);
      fwd_rd_en = 1'b0;
      fwd_done  = 1'b0;

      // Mid-packet reset: last_grant=1 so VM3 is next
      vm_ready_for_fwd = 4'b1000;
      wait_grant(3);
      rst = 1'b0;
      tick();
      fwd_done  = 1'b1;
      fwd_rd_en = 1'b1;
      #1;
      chk("mid_rst_ready", 64'(fwd_ready), 64'd0);
      chk("mid_rst_sel", 64'(fwd_sel), 64'd0);
      chk("mid_rst_done", 64'(vm_fwd_done), 64'd0);
      chk("mid_rst_rd_en", 64'(vm_fwd_rd_en), 64'd0);
`ifdef FWD_ARB_PKT_COUNT_EN
      chk("mid_rst_count", 64'(pkt_count), 64'd0);
`endif
      fwd_done         = 1'b0;
      fwd_rd_en        = 1'b0;
      vm_ready_for_fwd = 4'b1111;
      tick();
      rst = 1'b1;

      // Five packets after reset restart from VM0
      for (int p = 0; p < 5; p++) begin
         wait_grant(p % 4);
         pkt(p % 4, 10'(10'h200 + p * 8));
      end
`ifdef FWD_ARB_PKT_COUNT_EN
      chk("pkt_count_5", 64'(pkt_count), 64'd5);
`endif

      wait_grant(1);
`ifdef FWD_ARB_PKT_COUNT_EN
      dut.pkt_count_reg = 32'hFFFF_FFFF;
      #1;
      chk("pkt_count_preset", 64'(pkt_count), 64'hFFFF_FFFF);
`endif
      pkt(1, 10'h2F0);
`ifdef FWD_ARB_PKT_COUNT_EN
      chk("pkt_count_wrap", 64'(pkt_count), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
